// File: rtl/pi_spi_bridge.sv
// pi_spi_bridge: SPI slave (mode 0, MSB first) that turns MCU frames into
// byte-wide PI bus reads and writes, with region chip-selects, a one-deep
// write pending register and a read prefetch register.
module pi_spi_bridge #(
    parameter int RD_CYCLES = 4,
    parameter int WR_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ss_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] pi_addr,
    output logic [7:0]  pi_do,
    input  logic [7:0]  pi_din,
    output logic        pi_oe,
    output logic        pi_we_hi,
    output logic        pi_we_lo,
    output logic        pi_ce_rom0,
    output logic        pi_ce_rom1,
    output logic        pi_ce_sram,
    output logic        pi_ce_bram,
    output logic        pi_busy,
    output logic        pi_act,
    output logic        pi_ovf
);
    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RTURN, S_RDATA} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ss_sync_q, ss_sync_d;     // [1:0] synchroniser, [2] previous sample
    logic [2:0]       sck_sync_q, sck_sync_d;
    logic [1:0]       mosi_sync_q, mosi_sync_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       rx_q, rx_d;
    logic [1:0]       addr_cnt_q, addr_cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [7:0]       tx_q, tx_d;
    logic [31:0]      addr_q, addr_d;
    logic [7:0]       do_q, do_d;
    logic             oe_q, oe_d, we_hi_q, we_hi_d, we_lo_q, we_lo_d;
    logic             busy_q, busy_d, acc_rd_q, acc_rd_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [7:0]       pend_q, pend_d, pref_q, pref_d;
    logic             pend_v_q, pend_v_d, act_q, act_d, ovf_q, ovf_d;

    logic       ss_fall, ss_rise, sck_rise, sck_fall, in_frame, byte_done;
    logic [7:0] rx_byte, wr_byte;
    logic       eng_free, new_wr, start_rd, wr_go, rd_go;
    logic       hit_rom0, hit_rom1, hit_sram, hit_bram, region_ok;

    // Region decode from the current address; selects are qualified by an
    // access in progress so the bus is quiet while idle.
    always_comb begin
        hit_rom0  = (addr_q[31:24] == 8'h00);
        hit_rom1  = (addr_q[31:24] == 8'h01);
        hit_sram  = (addr_q[31:24] == 8'h02);
        hit_bram  = (addr_q[31:24] == 8'h03);
        region_ok = hit_rom0 | hit_rom1 | hit_sram | hit_bram;
    end

    // Next-state logic: synchronisers, SPI frame FSM, PI access engine.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        ss_sync_d   = {ss_sync_q[1:0], spi_ss_n};
        sck_sync_d  = {sck_sync_q[1:0], spi_sck};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        addr_cnt_d = addr_cnt_q;
        is_wr_d    = is_wr_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        do_d       = do_q;
        oe_d       = oe_q;
        we_hi_d    = we_hi_q;
        we_lo_d    = we_lo_q;
        busy_d     = busy_q;
        acc_rd_d   = acc_rd_q;
        acc_cnt_d  = acc_cnt_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        pref_d     = pref_q;
        act_d      = act_q;
        ovf_d      = ovf_q;
        new_wr     = 1'b0;
        start_rd   = 1'b0;
        wr_go      = 1'b0;
        rd_go      = 1'b0;
        wr_byte    = 8'h00;

        ss_fall   = ss_sync_q[2] & ~ss_sync_q[1];
        ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
        sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
        in_frame  = (state_q != S_IDLE);
        byte_done = in_frame & sck_rise & (bit_cnt_q == 3'd7);
        rx_byte   = {rx_q, mosi_sync_q[1]};
        eng_free  = ~busy_q | (acc_cnt_q == '0);

        // Access engine: count down the strobe, close it, step the address.
        if (busy_q) begin
            if (acc_cnt_q == '0) begin
                oe_d    = 1'b0;
                we_hi_d = 1'b0;
                we_lo_d = 1'b0;
                busy_d  = 1'b0;
                addr_d  = addr_q + 32'd1;
                if (acc_rd_q) pref_d = region_ok ? pi_din : 8'hFF;
            end else begin
                acc_cnt_d = acc_cnt_q - 1'b1;
            end
        end

        // SPI frame handling.
        if (ss_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            ovf_d     = 1'b0;
            tx_d      = 8'hFF;
        end else if (ss_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            act_d     = 1'b0;
            tx_d      = 8'hFF;
        end else if (in_frame) begin
            if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte[6:0];
            end
            // The fall right after a byte boundary keeps the freshly loaded MSB.
            if (sck_fall && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b1};
            if (byte_done) begin
                case (state_q)
                    S_CMD: begin
                        is_wr_d    = rx_byte[7];
                        addr_cnt_d = 2'd0;
                        state_d    = S_ADDR;
                    end
                    S_ADDR: begin
                        addr_d     = {addr_q[23:0], rx_byte};
                        addr_cnt_d = addr_cnt_q + 2'd1;
                        if (addr_cnt_q == 2'd3) begin
                            act_d = 1'b1;
                            if (is_wr_q) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d  = S_RTURN;
                                tx_d     = 8'hFF;
                                start_rd = 1'b1;
                            end
                        end
                    end
                    S_WDATA: new_wr = 1'b1;
                    S_RTURN, S_RDATA: begin
                        state_d  = S_RDATA;
                        tx_d     = pref_q;
                        start_rd = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        // Issue: pending write first, then a fresh byte, then a read fetch.
        if (eng_free) begin
            if (pend_v_q) begin
                wr_go    = 1'b1;
                wr_byte  = pend_q;
                pend_v_d = new_wr;
                if (new_wr) pend_d = rx_byte;
            end else if (new_wr) begin
                wr_go   = 1'b1;
                wr_byte = rx_byte;
            end else if (start_rd) begin
                rd_go = 1'b1;
            end
        end else if (new_wr) begin
            if (pend_v_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_v_d = 1'b1;
                pend_d   = rx_byte;
            end
        end

        if (wr_go) begin
            do_d      = wr_byte;
            we_hi_d   = ~addr_d[0];
            we_lo_d   = addr_d[0];
            busy_d    = 1'b1;
            acc_rd_d  = 1'b0;
            acc_cnt_d = WR_LAST;
        end
        if (rd_go) begin
            oe_d      = 1'b1;
            busy_d    = 1'b1;
            acc_rd_d  = 1'b1;
            acc_cnt_d = RD_LAST;
        end
    end

    // State register; reset drops every strobe immediately.
    // NOTE: asynchronous reset so strobes fall even without a running clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ss_sync_q   <= 3'b111;
            sck_sync_q  <= 3'b000;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            addr_cnt_q  <= 2'd0;
            is_wr_q     <= 1'b0;
            tx_q        <= 8'hFF;
            addr_q      <= 32'd0;
            do_q        <= 8'd0;
            oe_q        <= 1'b0;
            we_hi_q     <= 1'b0;
            we_lo_q     <= 1'b0;
            busy_q      <= 1'b0;
            acc_rd_q    <= 1'b0;
            acc_cnt_q   <= '0;
            pend_q      <= 8'd0;
            pend_v_q    <= 1'b0;
            pref_q      <= 8'hFF;
            act_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            addr_cnt_q  <= addr_cnt_d;
            is_wr_q     <= is_wr_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            do_q        <= do_d;
            oe_q        <= oe_d;
            we_hi_q     <= we_hi_d;
            we_lo_q     <= we_lo_d;
            busy_q      <= busy_d;
            acc_rd_q    <= acc_rd_d;
            acc_cnt_q   <= acc_cnt_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            pref_q      <= pref_d;
            act_q       <= act_d;
            ovf_q       <= ovf_d;
        end
    end

    assign spi_miso   = tx_q[7];
    assign pi_addr    = addr_q;
    assign pi_do      = do_q;
    assign pi_oe      = oe_q;
    assign pi_we_hi   = we_hi_q;
    assign pi_we_lo   = we_lo_q;
    assign pi_busy    = busy_q;
    assign pi_act     = act_q;
    assign pi_ovf     = ovf_q;
    assign pi_ce_rom0 = busy_q & hit_rom0;
    assign pi_ce_rom1 = busy_q & hit_rom1;
    assign pi_ce_sram = busy_q & hit_sram;
    assign pi_ce_bram = busy_q & hit_bram;

endmodule

// File: tb/tb_pi_spi_bridge.sv
// Directed bench for pi_spi_bridge: instance a (RD=4, WR=3) covers writes,
// reads, abort, region rollover and reset; instance b (long write strobe)
// covers the pending register and the overrun flag.
module tb_pi_spi_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0, mosi = 1'b0, ss_a = 1'b1, ss_b = 1'b1;

    logic        miso_a, oe_a, whi_a, wlo_a, c0_a, c1_a, c2_a, c3_a, busy_a, act_a, ovf_a;
    logic [31:0] addr_a;
    logic [7:0]  do_a, din_a;
    logic        miso_b, oe_b, whi_b, wlo_b, c0_b, c1_b, c2_b, c3_b, busy_b, act_b, ovf_b;
    logic [31:0] addr_b;
    logic [7:0]  do_b, din_b;

    // Mapper model: read data is the low address byte xor 0x3C.
    assign din_a = addr_a[7:0] ^ 8'h3C;
    assign din_b = addr_b[7:0] ^ 8'h3C;

    always #5 clk = ~clk;

    pi_spi_bridge #(.RD_CYCLES(4), .WR_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst), .spi_ss_n(ss_a), .spi_sck(sck), .spi_mosi(mosi),
        .spi_miso(miso_a), .pi_addr(addr_a), .pi_do(do_a), .pi_din(din_a),
        .pi_oe(oe_a), .pi_we_hi(whi_a), .pi_we_lo(wlo_a),
        .pi_ce_rom0(c0_a), .pi_ce_rom1(c1_a), .pi_ce_sram(c2_a), .pi_ce_bram(c3_a),
        .pi_busy(busy_a), .pi_act(act_a), .pi_ovf(ovf_a));

    pi_spi_bridge #(.RD_CYCLES(4), .WR_CYCLES(70)) dut_b (
        .clk(clk), .rst(rst), .spi_ss_n(ss_b), .spi_sck(sck), .spi_mosi(mosi),
        .spi_miso(miso_b), .pi_addr(addr_b), .pi_do(do_b), .pi_din(din_b),
        .pi_oe(oe_b), .pi_we_hi(whi_b), .pi_we_lo(wlo_b),
        .pi_ce_rom0(c0_b), .pi_ce_rom1(c1_b), .pi_ce_sram(c2_b), .pi_ce_bram(c3_b),
        .pi_busy(busy_b), .pi_act(act_b), .pi_ovf(ovf_b));

    // Strobe log: kind 1 = we_hi, 2 = we_lo, 3 = oe; ce = {bram,sram,rom1,rom0}.
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [7:0]  dat;
        logic [3:0]  ce;
        int          len;
    } acc_t;

    acc_t log_a[64];
    acc_t log_b[64];
    int n_a = 0, n_b = 0, pk_a = 0, pk_b = 0, k_a, k_b;
    int ovl_a = 0, ovl_b = 0, bmis_a = 0, bmis_b = 0;
    int n_cmp = 0, n_bad = 0;

    always @(negedge clk) begin
        k_a = oe_a ? 3 : (whi_a ? 1 : (wlo_a ? 2 : 0));
        if (int'(oe_a) + int'(whi_a) + int'(wlo_a) > 1) ovl_a++;
        if (busy_a !== (oe_a | whi_a | wlo_a)) bmis_a++;
        if (k_a != 0 && k_a != pk_a && n_a < 64) begin
            log_a[n_a] = '{kind: k_a, addr: addr_a, dat: do_a, ce: {c3_a, c2_a, c1_a, c0_a}, len: 1};
            n_a++;
        end else if (k_a != 0 && k_a == pk_a && n_a > 0) begin
            log_a[n_a-1].len++;
        end
        pk_a = k_a;
    end

    always @(negedge clk) begin
        k_b = oe_b ? 3 : (whi_b ? 1 : (wlo_b ? 2 : 0));
        if (int'(oe_b) + int'(whi_b) + int'(wlo_b) > 1) ovl_b++;
        if (busy_b !== (oe_b | whi_b | wlo_b)) bmis_b++;
        if (k_b != 0 && k_b != pk_b && n_b < 64) begin
            log_b[n_b] = '{kind: k_b, addr: addr_b, dat: do_b, ce: {c3_b, c2_b, c1_b, c0_b}, len: 1};
            n_b++;
        end else if (k_b != 0 && k_b == pk_b && n_b > 0) begin
            log_b[n_b-1].len++;
        end
        pk_b = k_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 master: MOSI set while sck low, MISO sampled at the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            tick(half);
            rx[i] = miso_a;
            sck = 1'b1;
            tick(half);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int half, output logic [7:0] rx);
        spi_bits(tx, 8, half, rx);
    endtask

    initial begin
        logic [7:0] rx;
        int base;

        // Reset state
        tick(3);
        check("rst_miso", miso_a, 1);
        check("rst_addr", addr_a, 0);
        check("rst_strobes", {oe_a, whi_a, wlo_a, busy_a}, 0);
        check("rst_ce", {c3_a, c2_a, c1_a, c0_a}, 0);
        check("rst_act_ovf", {act_a, ovf_a, do_a}, 0);
        rst = 1'b0;
        tick(3);

        // Write frame: two bytes at 0x10 / 0x11
        base = n_a;
        ss_a = 1'b0; tick(3);
        spi_byte(8'h80, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h00, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h10, 4, rx);
        check("wr_act", act_a, 1);
        spi_byte(8'hA5, 4, rx); spi_byte(8'h5A, 4, rx);
        tick(3); ss_a = 1'b1; tick(10);
        check("wr_n", n_a - base, 2);
        check("wr0_kind", log_a[base].kind, 1);
        check("wr0_addr", log_a[base].addr, 32'h10);
        check("wr0_dat", log_a[base].dat, 8'hA5);
        check("wr0_ce", log_a[base].ce, 4'b0001);
        check("wr0_len", log_a[base].len, 3);
        check("wr1_kind", log_a[base+1].kind, 2);
        check("wr1_addr", log_a[base+1].addr, 32'h11);
        check("wr1_dat", log_a[base+1].dat, 8'h5A);
        check("wr1_len", log_a[base+1].len, 3);
        check("wr_addr_end", addr_a, 32'h12);
        check("wr_act_off", act_a, 0);

        // Read frame at 0x02000001
        base = n_a;
        ss_a = 1'b0; tick(3);
        spi_byte(8'h00, 4, rx);
        spi_byte(8'h02, 4, rx); spi_byte(8'h00, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h01, 4, rx);
        spi_byte(8'hFF, 4, rx); check("rd_turn", rx, 8'hFF);
        spi_byte(8'hFF, 4, rx); check("rd_d0", rx, 8'h3D);
        spi_byte(8'hFF, 4, rx); check("rd_d1", rx, 8'h3E);
        spi_byte(8'hFF, 4, rx); check("rd_d2", rx, 8'h3F);
        tick(3); ss_a = 1'b1; tick(10);
        check("rd_n_ge4", int'(n_a - base >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            check("rd_kind", log_a[base+i].kind, 3);
            check("rd_addr", log_a[base+i].addr, 32'h02000001 + i);
            check("rd_len", log_a[base+i].len, 4);
            check("rd_ce", log_a[base+i].ce, 4'b0100);
        end

        // Abort after 5 bits of a data byte
        ss_a = 1'b0; tick(3);
        spi_byte(8'h80, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h00, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h20, 4, rx);
        base = n_a;
        spi_bits(8'hFF, 5, 4, rx);
        tick(3); ss_a = 1'b1; tick(4);
        check("ab_act", act_a, 0);
        tick(10);
        check("ab_nostrobe", n_a - base, 0);
        check("ab_addr", addr_a, 32'h20);
        ss_a = 1'b0; tick(3);
        spi_byte(8'h80, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h00, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h30, 4, rx);
        spi_byte(8'hC3, 4, rx);
        tick(3); ss_a = 1'b1; tick(10);
        check("ab_next_n", n_a - base, 1);
        check("ab_next_kind", log_a[base].kind, 1);
        check("ab_next_addr", log_a[base].addr, 32'h30);
        check("ab_next_dat", log_a[base].dat, 8'hC3);

        // Overrun on instance b (70-cycle write strobe, 4-clk sck)
        ss_b = 1'b0; tick(3);
        spi_byte(8'h80, 2, rx);
        spi_byte(8'h00, 2, rx); spi_byte(8'h00, 2, rx);
        spi_byte(8'h00, 2, rx); spi_byte(8'h00, 2, rx);
        spi_byte(8'h11, 2, rx); spi_byte(8'h22, 2, rx); spi_byte(8'h33, 2, rx);
        tick(3); ss_b = 1'b1;
        tick(160);
        check("ov_flag", ovf_b, 1);
        check("ov_n", n_b, 2);
        check("ov0_addr", log_b[0].addr, 32'h0);
        check("ov0_dat", log_b[0].dat, 8'h11);
        check("ov0_len", log_b[0].len, 70);
        check("ov1_kind", log_b[1].kind, 2);
        check("ov1_addr", log_b[1].addr, 32'h1);
        check("ov1_dat", log_b[1].dat, 8'h22);
        check("ov_addr_end", addr_b, 32'h2);
        ss_b = 1'b0; tick(5);
        check("ov_clear", ovf_b, 0);
        ss_b = 1'b1; tick(5);

        // Region rollover 0x01FFFFFF -> 0x02000000
        base = n_a;
        ss_a = 1'b0; tick(3);
        spi_byte(8'h80, 4, rx);
        spi_byte(8'h01, 4, rx); spi_byte(8'hFF, 4, rx);
        spi_byte(8'hFF, 4, rx); spi_byte(8'hFF, 4, rx);
        spi_byte(8'h77, 4, rx); spi_byte(8'h88, 4, rx);
        tick(3); ss_a = 1'b1; tick(10);
        check("rg0_kind", log_a[base].kind, 2);
        check("rg0_addr", log_a[base].addr, 32'h01FFFFFF);
        check("rg0_ce", log_a[base].ce, 4'b0010);
        check("rg1_kind", log_a[base+1].kind, 1);
        check("rg1_addr", log_a[base+1].addr, 32'h02000000);
        check("rg1_ce", log_a[base+1].ce, 4'b0100);
        check("rg1_dat", log_a[base+1].dat, 8'h88);

        // Unmapped region read: no ce, data forced to 0xFF
        base = n_a;
        ss_a = 1'b0; tick(3);
        spi_byte(8'h00, 4, rx);
        spi_byte(8'h04, 4, rx); spi_byte(8'h00, 4, rx);
        spi_byte(8'h00, 4, rx); spi_byte(8'h00, 4, rx);
        spi_byte(8'hFF, 4, rx);
        spi_byte(8'hFF, 4, rx); check("un_data", rx, 8'hFF);
        tick(3); ss_a = 1'b1; tick(10);
        check("un_addr", log_a[base].addr, 32'h04000000);
        check("un_ce", log_a[base].ce, 4'b0000);
        check("un_kind", log_a[base].kind, 3);

        // Reset during a pi_oe window
        ss_a = 1'b0; tick(3);
        spi_byte(8'h00, 4, rx);
        spi_byte(8'h02, 4, rx); spi_byte(8'h00, 4, rx); spi_byte(8'h00, 4, rx);
        spi_bits(8'h40, 7, 4, rx);
        mosi = 1'b0; tick(4); sck = 1'b1;
        for (int i = 0; i < 12 && !oe_a; i++) @(negedge clk);
        check("rs_oe_seen", oe_a, 1);
        rst = 1'b1;
        #1;
        check("rs_oe", oe_a, 0);
        check("rs_miso", miso_a, 1);
        check("rs_busy", busy_a, 0);
        check("rs_addr", addr_a, 0);
        sck = 1'b0; ss_a = 1'b1;
        tick(2); rst = 1'b0; tick(8);
        check("rs_addr_hold", addr_a, 0);
        check("rs_idle", {oe_a, act_a}, 0);

        check("excl_a", ovl_a, 0);
        check("excl_b", ovl_b, 0);
        check("busy_win_a", bmis_a, 0);
        check("busy_win_b", bmis_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
